// File: rtl/fb_pkg.sv
// Purpose : shared types and defaults for the framebuffer pixel writer and the rasteriser.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: state encoding (matches axi_master_state), AXI OKAY code, RGB565 type,
//           default framebuffer geometry.
package fb_pkg;

  // Encoded values are visible on axi_master_state; the rasteriser compares against them.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ADDR     = 2'd1,
    ST_RUNNING  = 2'd2,
    ST_FINISHED = 2'd3
  } fb_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef logic [15:0] rgb565_t;

  localparam logic [31:0] FB_BASE_DFLT   = 32'h1000_0000;
  localparam int          FB_WIDTH_DFLT  = 640;
  localparam int          FB_HEIGHT_DFLT = 480;

endpackage

// File: rtl/fb_addr_calc.sv
// Purpose : map screen coordinates to a word-aligned framebuffer address plus byte strobe.
// Latency : combinational.
// Backpressure: none (pure function of inputs).
// Ports   : i_x, i_y     - unsigned pixel coordinates
//           o_awaddr     - word-aligned byte address of the 32-bit word holding the pixel
//           o_wstrb      - lanes 1:0 for an even halfword, lanes 3:2 for an odd halfword
//           o_in_range   - coordinates lie inside FB_WIDTH x FB_HEIGHT
module fb_addr_calc
  import fb_pkg::*;
#(
  parameter logic [31:0] FB_BASE   = FB_BASE_DFLT,
  parameter int          FB_WIDTH  = FB_WIDTH_DFLT,
  parameter int          FB_HEIGHT = FB_HEIGHT_DFLT
) (
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  output logic [31:0] o_awaddr,
  output logic [3:0]  o_wstrb,
  output logic        o_in_range
);

  logic [31:0] w_pix;
  logic [31:0] w_byte_addr;

  // Row stride equals the visible width; pixels are two bytes each.
  assign w_pix       = ({16'd0, i_y} * 32'(FB_WIDTH)) + {16'd0, i_x};
  assign w_byte_addr = FB_BASE + (w_pix << 1);

  assign o_awaddr   = w_byte_addr & 32'hFFFF_FFFC;
  assign o_wstrb    = w_byte_addr[1] ? 4'b1100 : 4'b0011;
  assign o_in_range = ({16'd0, i_x} < 32'(FB_WIDTH)) && ({16'd0, i_y} < 32'(FB_HEIGHT));

endmodule

// File: rtl/fb_pixel_writer.sv
// Purpose : turn each rising edge of w_en into one single-beat AXI4 write of an RGB565 pixel.
// Latency : request to awvalid 2 cycles; request to writes_done 4 cycles with AW/W/B ready.
// Backpressure: AW/W valids hold until handshaked; one request buffered while busy, further ones dropped and counted.
// Ports   : clk, rst (async active-high); fb_addr {x,y}, fb_data, w_en from the rasteriser;
//           axi_master_state / axi_master_writes_done back to the rasteriser;
//           m_axi_aw*/w*/b* single-beat AXI4 write master; err_count, overrun_count saturating.
// Option  : FB_PIXEL_CLIP_EN - off-screen pixels complete immediately without an AXI write.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter logic [31:0] FB_BASE   = FB_BASE_DFLT,
  parameter int          FB_WIDTH  = FB_WIDTH_DFLT,
  parameter int          FB_HEIGHT = FB_HEIGHT_DFLT,
  parameter int          ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      fb_addr,
  input  logic [15:0]      fb_data,
  input  logic             w_en,
  output logic [1:0]       axi_master_state,
  output logic             axi_master_writes_done,
  output logic [31:0]      m_axi_awaddr,
  output logic             m_axi_awvalid,
  input  logic             m_axi_awready,
  output logic [31:0]      m_axi_wdata,
  output logic [3:0]       m_axi_wstrb,
  output logic             m_axi_wvalid,
  input  logic             m_axi_wready,
  input  logic [1:0]       m_axi_bresp,
  input  logic             m_axi_bvalid,
  output logic             m_axi_bready,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] overrun_count
);

`ifdef FB_PIXEL_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic [ERR_W-1:0] CNT_ONE = ERR_W'(1);
  localparam logic [ERR_W-1:0] CNT_MAX = '1;

  fb_state_t   r_state, w_state_nxt;
  logic        r_w_en_q;
  logic [31:0] r_cur_addr;
  rgb565_t     r_cur_data;
  logic        r_pend_vld;
  logic [31:0] r_pend_addr;
  rgb565_t     r_pend_data;
  logic        r_awvalid, r_wvalid, r_done;
  logic [31:0] r_awaddr, r_wdata;
  logic [3:0]  r_wstrb;
  logic [ERR_W-1:0] r_err_cnt, r_ovr_cnt;

  logic        w_req, w_idle_start, w_load_pend;
  logic        w_req_to_cur, w_req_to_pend, w_req_drop, w_accept;
  logic        w_b_hs, w_to_running, w_skip_done, w_skip;
  logic [31:0] w_calc_awaddr;
  logic [3:0]  w_calc_wstrb;
  logic        w_in_range;

  fb_addr_calc #(
    .FB_BASE   (FB_BASE),
    .FB_WIDTH  (FB_WIDTH),
    .FB_HEIGHT (FB_HEIGHT)
  ) u_addr_calc (
    .i_x        (r_cur_addr[31:16]),
    .i_y        (r_cur_addr[15:0]),
    .o_awaddr   (w_calc_awaddr),
    .o_wstrb    (w_calc_wstrb),
    .o_in_range (w_in_range)
  );

  // Only the rising edge of the level w_en counts as a new pixel.
  assign w_req = w_en & ~r_w_en_q;

  // Pending is drained before a fresh request; the fresh one then takes the freed slot.
  assign w_idle_start  = (r_state == ST_IDLE) & (r_pend_vld | w_req);
  assign w_load_pend   = w_idle_start & r_pend_vld;
  assign w_req_to_cur  = w_req & (r_state == ST_IDLE) & ~r_pend_vld;
  assign w_req_to_pend = w_req & ~w_req_to_cur & (~r_pend_vld | w_load_pend);
  assign w_req_drop    = w_req & ~w_req_to_cur & ~w_req_to_pend;
  assign w_accept      = w_req_to_cur | w_req_to_pend;

  assign w_skip = CLIP_EN & ~w_in_range;
  assign w_b_hs = (r_state == ST_FINISHED) & m_axi_bvalid;

  always_comb begin
    w_state_nxt  = r_state;
    w_to_running = 1'b0;
    w_skip_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend_vld || w_req) w_state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        if (w_skip) begin
          w_state_nxt = ST_IDLE;
          w_skip_done = 1'b1;
        end else begin
          w_state_nxt  = ST_RUNNING;
          w_to_running = 1'b1;
        end
      end
      ST_RUNNING: begin
        // Each channel is finished once its valid has dropped or is handshaking now.
        if ((!r_awvalid || m_axi_awready) && (!r_wvalid || m_axi_wready))
          w_state_nxt = ST_FINISHED;
      end
      ST_FINISHED: begin
        if (m_axi_bvalid) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w_en_q    <= 1'b0;
      r_cur_addr  <= '0;
      r_cur_data  <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_done      <= 1'b0;
      r_err_cnt   <= '0;
      r_ovr_cnt   <= '0;
    end else begin
      r_w_en_q <= w_en;

      if (w_req_to_cur) begin
        r_cur_addr <= fb_addr;
        r_cur_data <= fb_data;
      end else if (w_load_pend) begin
        r_cur_addr <= r_pend_addr;
        r_cur_data <= r_pend_data;
      end

      if (w_req_to_pend) begin
        r_pend_vld  <= 1'b1;
        r_pend_addr <= fb_addr;
        r_pend_data <= fb_data;
      end else if (w_load_pend) begin
        r_pend_vld <= 1'b0;
      end

      if (w_to_running) begin
        r_awvalid <= 1'b1;
        r_wvalid  <= 1'b1;
        r_awaddr  <= w_calc_awaddr;
        r_wstrb   <= w_calc_wstrb;
        r_wdata   <= {r_cur_data, r_cur_data};
      end else begin
        if (r_awvalid && m_axi_awready) r_awvalid <= 1'b0;
        if (r_wvalid && m_axi_wready)   r_wvalid  <= 1'b0;
      end

      // A newly accepted request outranks a completion landing in the same cycle:
      // that request is still outstanding.
      if (w_accept)                      r_done <= 1'b0;
      else if (w_b_hs || w_skip_done)    r_done <= 1'b1;

      if (w_b_hs && (m_axi_bresp != AXI_RESP_OKAY) && (r_err_cnt != CNT_MAX))
        r_err_cnt <= r_err_cnt + CNT_ONE;

      if (w_req_drop && (r_ovr_cnt != CNT_MAX))
        r_ovr_cnt <= r_ovr_cnt + CNT_ONE;
    end
  end

  assign axi_master_state       = r_state;
  assign axi_master_writes_done = r_done;
  assign m_axi_awaddr           = r_awaddr;
  assign m_axi_awvalid          = r_awvalid;
  assign m_axi_wdata            = r_wdata;
  assign m_axi_wstrb            = r_wstrb;
  assign m_axi_wvalid           = r_wvalid;
  assign m_axi_bready           = (r_state == ST_FINISHED);
  assign err_count              = r_err_cnt;
  assign overrun_count          = r_ovr_cnt;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Purpose : directed self-checking bench for fb_pixel_writer.
// Latency : n/a.
// Backpressure: AXI readies and bvalid driven directly by the stimulus.
module tb_fb_pixel_writer;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk, rst;
  logic [31:0] fb_addr;
  logic [15:0] fb_data;
  logic        w_en;
  logic [1:0]  st;
  logic        wdone;
  logic [31:0] awaddr, wdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp;
  logic [7:0]  err_cnt, ovr_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int aw0, w0, b0;
  logic [31:0] last_awaddr, last_wdata;
  logic [3:0]  last_wstrb;

  fb_pixel_writer dut (
    .clk                    (clk),
    .rst                    (rst),
    .fb_addr                (fb_addr),
    .fb_data                (fb_data),
    .w_en                   (w_en),
    .axi_master_state       (st),
    .axi_master_writes_done (wdone),
    .m_axi_awaddr           (awaddr),
    .m_axi_awvalid          (awvalid),
    .m_axi_awready          (awready),
    .m_axi_wdata            (wdata),
    .m_axi_wstrb            (wstrb),
    .m_axi_wvalid           (wvalid),
    .m_axi_wready           (wready),
    .m_axi_bresp            (bresp),
    .m_axi_bvalid           (bvalid),
    .m_axi_bready           (bready),
    .err_count              (err_cnt),
    .overrun_count          (ovr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor: counts beats on each channel and keeps the last AW/W payload.
  always @(posedge clk) begin
    if (!rst) begin
      if (awvalid && awready) begin
        aw_cnt      = aw_cnt + 1;
        last_awaddr = awaddr;
      end
      if (wvalid && wready) begin
        w_cnt      = w_cnt + 1;
        last_wdata = wdata;
        last_wstrb = wstrb;
      end
      if (bvalid && bready) b_cnt = b_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One-cycle-high w_en pulse followed by one low cycle.
  task automatic pulse(input logic [15:0] x, input logic [15:0] y, input logic [15:0] d);
    fb_addr = {x, y};
    fb_data = d;
    w_en    = 1'b1;
    tick();
    w_en    = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; w_en = 1'b0; fb_addr = '0; fb_data = '0;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    tick();
    check("rst_state",   {30'd0, st},      32'd0);
    check("rst_awvalid", {31'd0, awvalid}, 32'd0);
    check("rst_wvalid",  {31'd0, wvalid},  32'd0);
    check("rst_bready",  {31'd0, bready},  32'd0);
    check("rst_done",    {31'd0, wdone},   32'd0);
    check("rst_awaddr",  awaddr,           32'd0);
    check("rst_wdata",   wdata,            32'd0);
    check("rst_wstrb",   {28'd0, wstrb},   32'd0);
    check("rst_err",     {24'd0, err_cnt}, 32'd0);
    check("rst_ovr",     {24'd0, ovr_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // (3,2): pix 1283, byte offset 0xA06 -> word 0xA04, odd halfword.
    fb_addr = {16'd3, 16'd2}; fb_data = 16'hF800; w_en = 1'b1;
    tick();
    check("t1_state_addr", {30'd0, st},      32'd1);
    check("t1_aw_early",   {31'd0, awvalid}, 32'd0);
    tick();
    check("t1_state_run",  {30'd0, st},      32'd2);
    check("t1_awvalid",    {31'd0, awvalid}, 32'd1);
    check("t1_wvalid",     {31'd0, wvalid},  32'd1);
    check("t1_awaddr",     awaddr,           BASE + 32'hA04);
    check("t1_wstrb",      {28'd0, wstrb},   32'hC);
    check("t1_wdata",      wdata,            32'hF800_F800);
    tick();
    check("t1_state_fin",  {30'd0, st},      32'd3);
    check("t1_bready",     {31'd0, bready},  32'd1);
    check("t1_done_early", {31'd0, wdone},   32'd0);
    tick();
    check("t1_done",       {31'd0, wdone},   32'd1);
    check("t1_state_idle", {30'd0, st},      32'd0);
    repeat (4) tick();
    check("t1_level_noreq", aw_cnt,          32'd1);
    w_en = 1'b0;
    tick();

    // (1,0): byte offset 2 -> word 0, odd halfword; AW stalled, W immediate.
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    awready = 1'b0;
    fb_addr = {16'd1, 16'd0}; fb_data = 16'h1234; w_en = 1'b1;
    tick();
    check("t2_done_clr",  {31'd0, wdone},   32'd0);
    tick();
    check("t2_awvalid",   {31'd0, awvalid}, 32'd1);
    tick();
    check("t2_wvalid_drop", {31'd0, wvalid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("t2_aw_hold", {31'd0, awvalid}, 32'd1);
      if (i < 3) tick();
    end
    awready = 1'b1;
    tick();
    check("t2_aw_drop",   {31'd0, awvalid}, 32'd0);
    check("t2_state_fin", {30'd0, st},      32'd3);
    tick();
    check("t2_done",      {31'd0, wdone},   32'd1);
    check("t2_awaddr",    last_awaddr,      BASE);
    check("t2_wstrb",     {28'd0, last_wstrb}, 32'hC);
    check("t2_wdata",     last_wdata,       32'h1234_1234);
    check("t2_w_beats",   w_cnt - w0,       32'd1);
    check("t2_b_beats",   b_cnt - b0,       32'd1);
    w_en = 1'b0;
    tick();

    // Three pulses during a stalled write: second buffered, third dropped.
    aw0 = aw_cnt; b0 = b_cnt;
    awready = 1'b0;
    pulse(16'd5, 16'd1, 16'hAAAA);
    pulse(16'd6, 16'd1, 16'h5555);
    pulse(16'd20, 16'd1, 16'h0F0F);
    check("t3_ovr",      {24'd0, ovr_cnt}, 32'd1);
    awready = 1'b1;
    repeat (12) tick();
    check("t3_state",    {30'd0, st},      32'd0);
    check("t3_aw_beats", aw_cnt - aw0,     32'd2);
    check("t3_b_beats",  b_cnt - b0,       32'd2);
    check("t3_awaddr",   last_awaddr,      BASE + 32'h50C);
    check("t3_wstrb",    {28'd0, last_wstrb}, 32'h3);
    check("t3_wdata",    last_wdata,       32'h5555_5555);
    check("t3_done",     {31'd0, wdone},   32'd1);

    // Error responses and saturation.
    bresp = 2'b10;
    pulse(16'd0, 16'd0, 16'h0001);
    repeat (4) tick();
    check("t4_err1",  {24'd0, err_cnt}, 32'd1);
    check("t4_done",  {31'd0, wdone},   32'd1);
    for (int i = 0; i < 299; i++) begin
      pulse(16'd0, 16'd0, 16'h0001);
      repeat (4) tick();
    end
    check("t4_err_sat", {24'd0, err_cnt}, 32'd255);
    bresp = 2'b00;

    // (640,0): just off-screen on the right.
    aw0 = aw_cnt;
    fb_addr = {16'd640, 16'd0}; fb_data = 16'h07E0; w_en = 1'b1;
    tick();
    tick();
`ifdef FB_PIXEL_CLIP_EN
    check("t5_clip_state",   {30'd0, st},      32'd0);
    check("t5_clip_done",    {31'd0, wdone},   32'd1);
    check("t5_clip_awvalid", {31'd0, awvalid}, 32'd0);
    repeat (3) tick();
    check("t5_clip_noaw",    aw_cnt - aw0,     32'd0);
`else
    check("t5_awvalid",      {31'd0, awvalid}, 32'd1);
    check("t5_awaddr",       awaddr,           BASE + 32'h500);
    check("t5_wstrb",        {28'd0, wstrb},   32'h3);
    repeat (3) tick();
    check("t5_done",         {31'd0, wdone},   32'd1);
`endif
    w_en = 1'b0;
    tick();

    // Reset asserted mid-transfer takes effect without a clock edge.
    awready = 1'b0;
    fb_addr = {16'd2, 16'd2}; fb_data = 16'hFFFF; w_en = 1'b1;
    tick();
    tick();
    check("t6_pre_awvalid", {31'd0, awvalid}, 32'd1);
    rst = 1'b1;
    #1;
    check("t6_awvalid", {31'd0, awvalid}, 32'd0);
    check("t6_wvalid",  {31'd0, wvalid},  32'd0);
    check("t6_state",   {30'd0, st},      32'd0);
    check("t6_err",     {24'd0, err_cnt}, 32'd0);
    check("t6_ovr",     {24'd0, ovr_cnt}, 32'd0);
    check("t6_done",    {31'd0, wdone},   32'd0);
    w_en = 1'b0;
    tick();
    rst = 1'b0;
    awready = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
